// File: rtl/wmem_wr_arbiter_if.sv
// Write-port bundle between the two requesters, the clear control and the
// wide write side of the waveform RAM.
interface wmem_wr_arbiter_if #(
    parameter int DATAWIDTH = 16,
    parameter int ADDRWIDTH = 8
);
    logic                 req0_valid;
    logic                 req0_ready;
    logic [ADDRWIDTH-1:0] req0_addr;
    logic [DATAWIDTH-1:0] req0_data;
    logic                 req1_valid;
    logic                 req1_ready;
    logic [ADDRWIDTH-1:0] req1_addr;
    logic [DATAWIDTH-1:0] req1_data;
    logic                 clr_start;
    logic [DATAWIDTH-1:0] clr_value;
    logic                 clr_busy;
    logic                 ram_we;
    logic [ADDRWIDTH-1:0] ram_addr;
    logic [DATAWIDTH-1:0] ram_di;
    logic                 addr_err;

    modport master (
        output req0_valid, req0_addr, req0_data,
        output req1_valid, req1_addr, req1_data,
        output clr_start, clr_value,
        input  req0_ready, req1_ready, clr_busy,
        input  ram_we, ram_addr, ram_di, addr_err
    );

    modport slave (
        input  req0_valid, req0_addr, req0_data,
        input  req1_valid, req1_addr, req1_data,
        input  clr_start, clr_value,
        output req0_ready, req1_ready, clr_busy,
        output ram_we, ram_addr, ram_di, addr_err
    );
endinterface

// File: rtl/wmem_wr_arbiter.sv
// Round-robin, burst-locked arbiter for the waveform RAM wide write port with a
// memory-fill sequencer. Define WMEM_ADDR_GUARD_EN to drop and flag writes at or above ADDR_LIMIT.
module wmem_wr_arbiter #(
    parameter int DATAWIDTH  = 16,
    parameter int ADDRWIDTH  = 8,
    parameter int MAX_BURST  = 16,
    parameter int ADDR_LIMIT = 256
) (
    input  logic             clk,
    input  logic             rstn,
    wmem_wr_arbiter_if.slave bus
);
    localparam int BW = $clog2(MAX_BURST) + 1;
    localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);

    if (MAX_BURST < 2 || MAX_BURST > 256 || ADDR_LIMIT < 1 || ADDR_LIMIT > (2 ** ADDRWIDTH)) begin : gParamChk
        $error("wmem_wr_arbiter: MAX_BURST or ADDR_LIMIT out of range");
    end

    typedef enum logic [1:0] {IDLE, GNT0, GNT1, CLEAR} state_t;

    state_t               state, nextState;
    logic                 rrPtr, nextPtr;
    logic [BW-1:0]        burstCnt;
    logic                 grant0, grant1, accept, inRange;
    logic [ADDRWIDTH-1:0] selAddr;
    logic [DATAWIDTH-1:0] selData;
    logic [ADDRWIDTH-1:0] clrAddr;
    logic [DATAWIDTH-1:0] clrValue;
    logic                 clrBusy;
    logic                 ramWe;
    logic [ADDRWIDTH-1:0] ramAddr;
    logic [DATAWIDTH-1:0] ramDi;

    assign accept  = grant0 | grant1;
    assign selAddr = grant1 ? bus.req1_addr : bus.req0_addr;
    assign selData = grant1 ? bus.req1_data : bus.req0_data;

`ifdef WMEM_ADDR_GUARD_EN
    localparam logic [ADDRWIDTH:0]   LIMIT    = (ADDRWIDTH + 1)'(ADDR_LIMIT);
    localparam logic [ADDRWIDTH-1:0] CLR_LAST = ADDRWIDTH'(ADDR_LIMIT - 1);
    logic addrErr;

    assign inRange = ({1'b0, selAddr} < LIMIT);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            addrErr <= 1'b0;
        end else if (accept && !inRange) begin
            addrErr <= 1'b1;
        end
    end

    assign bus.addr_err = addrErr;
`else
    localparam logic [ADDRWIDTH-1:0] CLR_LAST = '1;

    assign inRange      = 1'b1;
    assign bus.addr_err = 1'b0;
`endif

    // rrPtr=1 favours req1. clrBusy trails the CLEAR state by one cycle so it lines
    // up with the registered ram_we; IDLE holds off requests until it has dropped.
    always_comb begin
        nextState = state;
        nextPtr   = rrPtr;
        grant0    = 1'b0;
        grant1    = 1'b0;
        case (state)
            IDLE: begin
                if (!clrBusy) begin
                    if (bus.clr_start) begin
                        nextState = CLEAR;
                    end else if (bus.req0_valid && (!bus.req1_valid || !rrPtr)) begin
                        grant0    = 1'b1;
                        nextState = GNT0;
                    end else if (bus.req1_valid) begin
                        grant1    = 1'b1;
                        nextState = GNT1;
                    end
                end
            end
            GNT0: begin
                if (bus.clr_start) begin
                    nextState = CLEAR;
                    nextPtr   = 1'b1;
                end else if (!bus.req0_valid || burstCnt == BURST_MAX) begin
                    nextState = IDLE;
                    nextPtr   = 1'b1;
                end else begin
                    grant0 = 1'b1;
                end
            end
            GNT1: begin
                if (bus.clr_start) begin
                    nextState = CLEAR;
                    nextPtr   = 1'b0;
                end else if (!bus.req1_valid || burstCnt == BURST_MAX) begin
                    nextState = IDLE;
                    nextPtr   = 1'b0;
                end else begin
                    grant1 = 1'b1;
                end
            end
            CLEAR: begin
                if (clrAddr == CLR_LAST) begin
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= IDLE;
            rrPtr    <= 1'b0;
            burstCnt <= '0;
            clrAddr  <= '0;
            clrValue <= '0;
            clrBusy  <= 1'b0;
            ramWe    <= 1'b0;
            ramAddr  <= '0;
            ramDi    <= '0;
        end else begin
            state   <= nextState;
            rrPtr   <= nextPtr;
            clrBusy <= (state == CLEAR);

            if (accept) begin
                burstCnt <= (state == IDLE) ? BW'(1) : burstCnt + 1'b1;
            end else if (nextState != state) begin
                burstCnt <= '0;
            end

            if (state != CLEAR && nextState == CLEAR) begin
                clrAddr  <= '0;
                clrValue <= bus.clr_value;
            end else if (state == CLEAR) begin
                clrAddr <= clrAddr + 1'b1;
            end

            ramWe <= 1'b0;
            if (state == CLEAR) begin
                ramWe   <= 1'b1;
                ramAddr <= clrAddr;
                ramDi   <= clrValue;
            end else if (accept) begin
                ramWe   <= inRange;
                ramAddr <= selAddr;
                ramDi   <= selData;
            end
        end
    end

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;
    assign bus.clr_busy   = clrBusy;
    assign bus.ram_we     = ramWe;
    assign bus.ram_addr   = ramAddr;
    assign bus.ram_di     = ramDi;
endmodule

// File: tb/tb_wmem_wr_arbiter.sv
// Directed bench for wmem_wr_arbiter: the driver queues expected RAM writes
// (cycle, address, data); a negedge monitor pops and compares each ram_we.
module tb_wmem_wr_arbiter;
    localparam int DW = 16;
    localparam int AW = 8;
`ifdef WMEM_ADDR_GUARD_EN
    localparam int CLR_N = 200;
    localparam bit GUARD = 1'b1;
`else
    localparam int CLR_N = 256;
    localparam bit GUARD = 1'b0;
`endif

    logic        clk  = 1'b0;
    logic        rstn = 1'b0;
    int unsigned cyc  = 0;
    int          nVec = 0;
    int          nErr = 0;
    logic        expErr = 1'b0;

    typedef struct packed {
        int unsigned   wcyc;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wrT;
    wrT expQ[$];
    wrT monE;

    wmem_wr_arbiter_if #(.DATAWIDTH(DW), .ADDRWIDTH(AW)) bus ();

    wmem_wr_arbiter #(
        .DATAWIDTH (DW),
        .ADDRWIDTH (AW),
        .MAX_BURST (4),
        .ADDR_LIMIT(200)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic bit tbInRange(input logic [AW-1:0] a);
        return (GUARD == 1'b0) || (int'(a) < 200);
    endfunction

    always @(negedge clk) begin
        if (bus.ram_we === 1'b1) begin
            if (expQ.size() == 0) begin
                nVec++;
                nErr++;
                $display("FAIL unexpectedWrite at cycle %0d: got addr %0h data %0h, expected no write",
                         cyc, bus.ram_addr, bus.ram_di);
            end else begin
                monE = expQ.pop_front();
                chk("wrCycle", cyc, monE.wcyc);
                chk("wrAddr", 32'(bus.ram_addr), 32'(monE.a));
                chk("wrData", 32'(bus.ram_di), 32'(monE.d));
            end
        end
    end

    // One clock of stimulus: drive, check readies/busy/addr_err at negedge, queue expected writes.
    task automatic step(input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                        input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                        input logic clr, input logic er0, input logic er1, input logic eb);
        bus.req0_valid = v0;
        bus.req0_addr  = a0;
        bus.req0_data  = d0;
        bus.req1_valid = v1;
        bus.req1_addr  = a1;
        bus.req1_data  = d1;
        bus.clr_start  = clr;
        @(negedge clk);
        chk("ready0", 32'(bus.req0_ready), 32'(er0));
        chk("ready1", 32'(bus.req1_ready), 32'(er1));
        chk("clrBusy", 32'(bus.clr_busy), 32'(eb));
        chk("addrErr", 32'(bus.addr_err), 32'(expErr));
        if (er0 && tbInRange(a0)) expQ.push_back('{cyc + 1, a0, d0});
        if (er1 && tbInRange(a1)) expQ.push_back('{cyc + 1, a1, d1});
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, '0, '0, 0, '0, '0, 0, 0, 0, 0);
    endtask

    task automatic doReset();
        rstn           = 1'b0;
        bus.req0_valid = 1'b0;
        bus.req0_addr  = '0;
        bus.req0_data  = '0;
        bus.req1_valid = 1'b0;
        bus.req1_addr  = '0;
        bus.req1_data  = '0;
        bus.clr_start  = 1'b0;
        bus.clr_value  = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rstReady0", 32'(bus.req0_ready), 32'd0);
        chk("rstReady1", 32'(bus.req1_ready), 32'd0);
        chk("rstRamWe", 32'(bus.ram_we), 32'd0);
        chk("rstBusy", 32'(bus.clr_busy), 32'd0);
        chk("rstAddrErr", 32'(bus.addr_err), 32'd0);
        chk("rstRamAddr", 32'(bus.ram_addr), 32'd0);
        chk("rstRamDi", 32'(bus.ram_di), 32'd0);
        @(posedge clk);
        #1;
        rstn   = 1'b1;
        expErr = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int i0;
        int i1;
        int unsigned cyc0;
        @(posedge clk);
        #1;
        doReset();

        // single write
        step(1, 8'h05, 16'h1234, 0, '0, '0, 0, 1, 0, 0);
        step(0, '0, '0, 0, '0, '0, 0, 0, 0, 0);
        idle(2);

        // contention, MAX_BURST=4: 4x req0, bubble, 4x req1, bubble, 4x req0
        doReset();
        i0 = 0;
        i1 = 0;
        for (int k = 0; k < 14; k++) begin
            logic e0;
            logic e1;
            e0 = ((k % 10) < 4);
            e1 = ((k % 10) >= 5) && ((k % 10) <= 8);
            step(1, AW'(8'h40 + i0), DW'(16'hA000 + i0), 1, AW'(8'h80 + i1), DW'(16'hB000 + i1),
                 0, e0, e1, 0);
            if (e0) i0++;
            if (e1) i1++;
        end
        idle(2);

        // owner drop and pointer handover
        doReset();
        step(1, 8'h01, 16'h0101, 0, '0, '0, 0, 1, 0, 0);
        step(0, '0, '0, 0, '0, '0, 0, 0, 0, 0);
        step(1, 8'h02, 16'h0202, 1, 8'h90, 16'h9090, 0, 0, 1, 0);
        step(0, '0, '0, 0, '0, '0, 0, 0, 0, 0);
        step(0, '0, '0, 1, 8'h91, 16'h9191, 0, 0, 1, 0);
        step(0, '0, '0, 1, 8'h92, 16'h9292, 0, 0, 1, 0);
        step(0, '0, '0, 0, '0, '0, 0, 0, 0, 0);
        step(1, 8'h03, 16'h0303, 1, 8'h93, 16'h9393, 0, 1, 0, 0);
        idle(2);

        // address guard: addr 210 accepted; written only without the guard
        doReset();
        step(1, 8'hD2, 16'hDEAD, 0, '0, '0, 0, 1, 0, 0);
        expErr = GUARD;
        step(1, 8'h0A, 16'hBEEF, 0, '0, '0, 0, 1, 0, 0);
        idle(3);

        // clear entered from a grant, req0 pending throughout, restart attempt ignored
        doReset();
        step(1, 8'h20, 16'h1111, 0, '0, '0, 0, 1, 0, 0);
        bus.clr_value = 16'h7FFF;
        cyc0 = cyc;
        for (int i = 0; i < CLR_N; i++) expQ.push_back('{cyc0 + 2 + i, AW'(i), 16'h7FFF});
        for (int k = 0; k <= CLR_N + 2; k++) begin
            if (k == 1) bus.clr_value = 16'h0F0F;
            step(1, 8'h33, 16'hC0DE, 0, '0, '0, (k == 0) || (k == 50),
                 (k == CLR_N + 2), 0, (k >= 2) && (k <= CLR_N + 1));
        end
        idle(2);

        // reset during clear at address 100
        doReset();
        bus.clr_value = 16'h5A5A;
        cyc0 = cyc;
        for (int i = 0; i <= 100; i++) expQ.push_back('{cyc0 + 2 + i, AW'(i), 16'h5A5A});
        for (int k = 0; k <= 101; k++) begin
            step(0, '0, '0, (k == 0), 8'h77, 16'h7777, (k == 0), 0, 0, (k >= 2));
        end
        rstn = 1'b0;
        step(0, '0, '0, 0, '0, '0, 0, 0, 0, 1);
        rstn = 1'b1;
        step(1, 8'h44, 16'h4444, 0, '0, '0, 0, 1, 0, 0);
        step(0, '0, '0, 0, '0, '0, 0, 0, 0, 0);
        idle(3);

        chk("queueEmpty", 32'(expQ.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end
endmodule
